// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the low-frequency counter datapath.
// Divider state encoding and the microsecond scale constant.
package freq_counter_pkg;

  localparam int DIV_W = 20;
  localparam int unsigned US_PER_SEC = 1_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// start/ready/done handshake plus operand and result buses
// shared by the divider and the stages around it.
interface seq_restoring_divider_if
  import freq_counter_pkg::*;
#(
  parameter int W = DIV_W
);

  logic         start_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         ready_o;
  logic         done_o;
  logic         err_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;

  modport master (
    output start_i,
    output dividend_i,
    output divisor_i,
    input  ready_o,
    input  done_o,
    input  err_o,
    input  quotient_o,
    input  remainder_o
  );

  modport slave (
    input  start_i,
    input  dividend_i,
    input  divisor_i,
    output ready_o,
    output done_o,
    output err_o,
    output quotient_o,
    output remainder_o
  );

endinterface

// File: rtl/seq_restoring_divider_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if no borrow.
module div_step #(
  parameter int W = 20
) (
  input  logic [W-1:0] rem_i,
  input  logic         dq_msb_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] rs;
  logic [W:0] diff;

  assign rs   = {rem_i, dq_msb_i};
  assign diff = rs - {1'b0, divisor_i};

  // rem < divisor keeps rs < 2*divisor, so bit W is a pure borrow
  assign q_o   = ~diff[W];
  assign rem_o = q_o ? diff[W-1:0] : rs[W-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit
// per cycle, chained by start/ready/done.
module seq_restoring_divider
  import freq_counter_pkg::*;
#(
  parameter int W = DIV_W
) (
  input logic                    clk_i,
  input logic                    reset_i,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

  div_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] dq_q, dq_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rmd_q, rmd_d;
  logic         err_q, err_d;

  logic [W-1:0] step_rem;
  logic         step_bit;

  div_step #(.W(W)) u_step (
    .rem_i     (rem_q),
    .dq_msb_i  (dq_q[W-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_bit)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= CNT_INIT;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.divisor_i != '0) begin
            dq_d    = bus.dividend_i;
            dvs_d   = bus.divisor_i;
            rem_d   = '0;
            cnt_d   = CNT_INIT;
            err_d   = 1'b0;
            state_d = OP;
          end else begin
            quo_d   = '1;
            rmd_d   = bus.dividend_i;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      OP: begin
        rem_d = step_rem;
        dq_d  = {dq_q[W-2:0], step_bit};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          quo_d   = {dq_q[W-2:0], step_bit};
          rmd_d   = step_rem;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.done_o      = (state_q == DONE);
  assign bus.err_o       = err_q;
  assign bus.quotient_o  = quo_q;
  assign bus.remainder_o = rmd_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: cycle-level model plus
// directed operations with literal expectations.
module tb_seq_restoring_divider;
  import freq_counter_pkg::*;

  localparam int W = DIV_W;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  seq_restoring_divider_if #(.W(W)) bus ();

  seq_restoring_divider #(.W(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: timing from accept cycle, results from plain / and %
  int           cyc      = 0;
  int           ready_at = 0;
  int           done_at  = -1;
  bit           m_en     = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_err = 1'b0, p_err = 1'b0;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_en     = 1'b1;
      ready_at = cyc;
      done_at  = -1;
      m_q      = '0;
      m_r      = '0;
      m_err    = 1'b0;
    end else begin
      if (cyc >= ready_at && bus.start_i) begin
        if (bus.divisor_i == '0) begin
          p_q     = '1;
          p_r     = bus.dividend_i;
          p_err   = 1'b1;
          done_at = cyc + 1;
        end else begin
          p_q     = bus.dividend_i / bus.divisor_i;
          p_r     = bus.dividend_i % bus.divisor_i;
          p_err   = 1'b0;
          m_err   = 1'b0;
          done_at = cyc + W + 1;
        end
        ready_at = done_at + 1;
      end
      cyc++;
      if (cyc == done_at) begin
        m_q   = p_q;
        m_r   = p_r;
        m_err = p_err;
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_en && !reset_i) begin
      chk("m_ready", bus.ready_o, longint'(cyc >= ready_at));
      chk("m_done", bus.done_o, longint'(cyc == done_at));
      chk("m_quot", bus.quotient_o, m_q);
      chk("m_rem", bus.remainder_o, m_r);
      chk("m_err", bus.err_o, m_err);
    end
  end

  task automatic drv();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    @(negedge clk_i);
    while (!bus.done_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  task automatic do_op(input string nm, input int a, input int b,
                       input int eq, input int er, input int ee,
                       input int elat);
    int n;
    drv();
    bus.start_i    = 1'b1;
    bus.dividend_i = W'(a);
    bus.divisor_i  = W'(b);
    drv();
    bus.start_i = 1'b0;
    wait_done(1, n);
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_q"}, bus.quotient_o, eq);
    chk({nm, "_r"}, bus.remainder_o, er);
    chk({nm, "_err"}, bus.err_o, ee);
    @(negedge clk_i);
    chk({nm, "_rdy_back"}, bus.ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses;
    bus.start_i    = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (3) drv();
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_done", bus.done_o, 0);
    chk("rst_q", bus.quotient_o, 0);
    chk("rst_r", bus.remainder_o, 0);
    chk("rst_err", bus.err_o, 0);
    reset_i = 1'b0;

    do_op("d1000", US_PER_SEC, 1000, 1000, 0, 0, 21);
    do_op("d7", US_PER_SEC, 7, 142857, 1, 0, 21);
    do_op("d5_9", 5, 9, 0, 5, 0, 21);
    do_op("dmax", 1048575, 1, 1048575, 0, 0, 21);
    do_op("dz", 1234, 0, 'hFFFFF, 1234, 1, 1);

    drv();
    bus.start_i    = 1'b1;
    bus.dividend_i = W'(US_PER_SEC);
    bus.divisor_i  = 20'd1000;
    drv();
    bus.start_i    = 1'b0;
    bus.dividend_i = 20'hABCDE;
    bus.divisor_i  = 20'd0;
    repeat (4) drv();
    bus.start_i    = 1'b1;
    bus.dividend_i = 20'd10;
    bus.divisor_i  = 20'd3;
    drv();
    bus.start_i = 1'b0;
    wait_done(6, n);
    chk("ign_lat", n, 21);
    chk("ign_q", bus.quotient_o, 1000);
    chk("ign_r", bus.remainder_o, 0);

    repeat (2) drv();
    bus.start_i    = 1'b1;
    bus.dividend_i = W'(US_PER_SEC);
    bus.divisor_i  = 20'd7;
    drv();
    bus.start_i = 1'b0;
    repeat (7) drv();
    reset_i = 1'b1;
    #1;
    chk("abort_ready", bus.ready_o, 1);
    chk("abort_done", bus.done_o, 0);
    chk("abort_q", bus.quotient_o, 0);
    chk("abort_r", bus.remainder_o, 0);
    chk("abort_err", bus.err_o, 0);
    repeat (2) drv();
    reset_i = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(negedge clk_i);
      if (bus.done_o) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    do_op("d100_10", 100, 10, 10, 0, 0, 21);

    drv();
    bus.start_i    = 1'b1;
    bus.dividend_i = 20'd1000;
    bus.divisor_i  = 20'd10;
    pulses = 0;
    repeat (2 * (W + 2)) begin
      @(negedge clk_i);
      if (bus.done_o) pulses++;
      drv();
    end
    bus.start_i = 1'b0;
    chk("b2b_pulses", pulses, 2);
    repeat (W + 4) @(negedge clk_i);
    chk("b2b_q", bus.quotient_o, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
